// File: rtl/neq3_share_arb.sv
// Round-robin sequencer that time-shares one registered not-all-equal stage among NREQ requesters.
// Optional saturating mismatch counter enabled by defining NEQ3_MISMATCH_CNT_EN.

module neq3_share_arb_lane #(
  parameter int IDW = 2,
  parameter int IDX = 0
) (
  input  logic           vld,
  input  logic [IDW-1:0] ptr,
  output logic           hi
);
  // Requester is eligible in the first (non-wrapped) search pass.
  assign hi = vld && (IDW'(IDX) >= ptr);
endmodule

module neq3_share_arb #(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 8,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [3*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_en,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_flag,
  output logic              busy
`ifdef NEQ3_MISMATCH_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  mis_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_RESP} state_t;

  if (NREQ < 1 || NREQ > 16 || CNT_W < 1) begin : g_bad_param
    $error("neq3_share_arb: NREQ must be 1..16 and CNT_W >= 1");
  end

  state_t            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [2:0]        op_data_q, op_data_d;
  logic              op_en_q, op_en_d;
  logic [IDW-1:0]    op_id_q, op_id_d;
  logic              rsp_flag_q, rsp_flag_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;

  logic [NREQ-1:0]   hi_mask;
  logic              sel_any, sel_hi_any;
  logic [IDW-1:0]    sel_idx;
  logic [NREQ-1:0]   sel_oh;
  logic [2:0]        sel_data;
  logic              sel_en;
  logic              hs;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    neq3_share_arb_lane #(.IDW(IDW), .IDX(gi)) u_lane (
      .vld (req_valid[gi]),
      .ptr (rr_ptr_q),
      .hi  (hi_mask[gi])
    );
  end

  // Two-pass round robin: lowest eligible index at/after rr_ptr, else lowest overall.
  always_comb begin
    sel_any    = |req_valid;
    sel_hi_any = |hi_mask;
    sel_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (sel_hi_any ? hi_mask[i] : req_valid[i]) sel_idx = IDW'(i);
    end
  end

  always_comb begin
    sel_oh   = '0;
    sel_data = '0;
    sel_en   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx == IDW'(i)) begin
        sel_oh[i] = 1'b1;
        sel_data  = req_data[3*i +: 3];
        sel_en    = req_en[i];
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_flag  = rsp_flag_q;
  assign hs        = rsp_valid && rsp_ready;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_data_d  = op_data_q;
    op_en_d    = op_en_q;
    op_id_d    = op_id_q;
    rsp_flag_d = rsp_flag_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;
    case (state_q)
      S_IDLE: begin
        if (sel_any) begin
          req_ready = sel_oh;
          op_data_d = sel_data;
          op_en_d   = sel_en;
          op_id_d   = sel_idx;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        rsp_flag_d = op_en_q &
                     ~((op_data_q[0] == op_data_q[1]) & (op_data_q[1] == op_data_q[2]));
        rsp_id_d   = op_id_q;
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          // With NREQ == 1 this always resolves to 0.
          rr_ptr_d = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + IDW'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      op_data_q  <= '0;
      op_en_q    <= 1'b0;
      op_id_q    <= '0;
      rsp_flag_q <= 1'b0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_data_q  <= op_data_d;
      op_en_q    <= op_en_d;
      op_id_q    <= op_id_d;
      rsp_flag_q <= rsp_flag_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

`ifdef NEQ3_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Clear takes precedence over a same-cycle increment.
  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (cnt_clr) begin
      mis_cnt_d = '0;
    end else if (hs && rsp_flag_q && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_cnt_q <= '0;
    else        mis_cnt_q <= mis_cnt_d;
  end

  assign mis_cnt = mis_cnt_q;
`endif

endmodule

// File: tb/tb_neq3_share_arb.sv
// Self-checking bench for neq3_share_arb: transaction-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.

module tb_neq3_share_arb;
  localparam int NREQ  = 4;
  localparam int CNT_W = 2;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [3*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_en = '0;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_flag;
  logic              busy;
`ifdef NEQ3_MISMATCH_CNT_EN
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  mis_cnt;
`endif

  neq3_share_arb #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_en    (req_en),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_flag  (rsp_flag),
    .busy      (busy)
`ifdef NEQ3_MISMATCH_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .mis_cnt   (mis_cnt)
`endif
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int gq[$];
  int tq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: one outstanding request, response two cycles after accept.
  bit         m_pend = 0;
  int         m_acc  = 0;
  int         m_id   = 0;
  bit         m_flag = 0;
  int         m_ptr  = 0;
  int         m_cnt  = 0;

  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int       p;
    bit       ev;
    bit       hsm;
    logic [2:0] d;
    logic [NREQ-1:0] er;
    cyc++;
    if (!rst_n) begin
      m_pend = 0; m_ptr = 0; m_cnt = 0;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_flag", 32'(rsp_flag), 0);
`ifdef NEQ3_MISMATCH_CNT_EN
      chk("rst_mis_cnt", 32'(mis_cnt), 0);
`endif
    end else begin
      p  = m_pend ? -1 : pick(req_valid, m_ptr);
      er = '0;
      if (p >= 0) er[p] = 1'b1;
      ev = m_pend && (cyc >= m_acc + 2);
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("busy", 32'(busy), 32'(m_pend));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_flag", 32'(rsp_flag), 32'(m_flag));
      end
`ifdef NEQ3_MISMATCH_CNT_EN
      chk("mis_cnt", 32'(mis_cnt), 32'(m_cnt));
`endif
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin gq.push_back(i); tq.push_back(cyc); end
      hsm = ev && rsp_ready;
`ifdef NEQ3_MISMATCH_CNT_EN
      if (cnt_clr) m_cnt = 0;
      else if (hsm && m_flag && m_cnt < (1 << CNT_W) - 1) m_cnt++;
`endif
      if (hsm) begin m_pend = 0; m_ptr = (m_id + 1) % NREQ; end
      if (p >= 0) begin
        d      = req_data[3*p +: 3];
        m_pend = 1; m_acc = cyc; m_id = p;
        m_flag = req_en[p] && !(d == 3'b000 || d == 3'b111);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output int idx);
    idx = -1;
    for (int i = 0; i < 20 && idx < 0; i++) begin
      @(negedge clk);
      for (int j = 0; j < NREQ; j++) if (req_ready[j]) idx = j;
    end
    if (idx < 0) chk("grant_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic single(input logic [2:0] d, input logic en, input logic ef, input string nm);
    int g;
    step();
    req_data[8:6] = d; req_en[2] = en; req_valid = 4'b0100; rsp_ready = 1'b1;
    wait_grant(g);
    chk({nm, "_ready"}, 32'(req_ready), 32'h4);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    chk({nm, "_t1_valid"}, 32'(rsp_valid), 0);
    @(negedge clk);
    chk({nm, "_t2_valid"}, 32'(rsp_valid), 1);
    chk({nm, "_id"}, 32'(rsp_id), 2);
    chk({nm, "_flag"}, 32'(rsp_flag), 32'(ef));
    step(2);
  endtask

  initial begin
    int g;
    int n0;
    int exp_ord[5];
    exp_ord = '{0, 1, 2, 3, 0};
    #2 rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;

    // Idle: nothing requested for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(req_ready), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    single(3'b101, 1'b1, 1'b1, "single_101");
    single(3'b111, 1'b1, 1'b0, "single_111");
    single(3'b010, 1'b0, 1'b0, "single_en0");

    // Round robin from reset with all four valid.
    do_reset();
    gq.delete(); tq.delete();
    req_data = {3'b011, 3'b010, 3'b110, 3'b101};
    req_en   = 4'b1011;
    req_valid = 4'hf; rsp_ready = 1'b1;
    for (int i = 0; i < 60 && gq.size() < 5; i++) @(negedge clk);
    @(posedge clk); #1 req_valid = '0;
    chk("rr_count", 32'(gq.size()), 5);
    if (gq.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(gq[i]), 32'(exp_ord[i]));
      for (int i = 0; i < 4; i++) chk("rr_spacing", 32'(tq[i+1] - tq[i]), 3);
    end
    step(4);

    // Backpressure: pointer now at 1, requesters 0 and 1 valid.
    rsp_ready = 1'b0; req_valid = 4'b0011;
    n0 = gq.size();
    wait_grant(g);
    chk("bp_grant", 32'(g), 1);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 1);
      chk("bp_flag", 32'(rsp_flag), 1);
      chk("bp_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    chk("bp_no_accept", 32'(gq.size()), 32'(n0 + 1));
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_grant(g);
    chk("bp_next_grant", 32'(g), 0);
    @(posedge clk); #1 req_valid = '0;
    step(4);

    // Reset while in EVAL drops the transaction; requester 0 regains priority.
    req_valid = 4'b0001;
    wait_grant(g);
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("midrst_valid", 32'(rsp_valid), 0);
    step(2);
    rst_n = 1'b1; req_valid = 4'b1010;
    wait_grant(g);
    chk("midrst_grant", 32'(g), 1);
    @(posedge clk); #1 req_valid = '0;
    step(4);

`ifdef NEQ3_MISMATCH_CNT_EN
    begin
      int ce[5];
      ce = '{1, 2, 3, 3, 3};
      do_reset();
      req_data[2:0] = 3'b001; req_en[0] = 1'b1; req_valid = 4'b0001; rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
        int w;
        w = 0;
        do @(negedge clk); while (!rsp_valid && ++w < 20);
        @(negedge clk);
        chk("cnt_sat", 32'(mis_cnt), 32'(ce[k]));
      end
      @(posedge clk); #1 rsp_ready = 1'b0;
      for (int w = 0; w < 20 && !rsp_valid; w++) @(negedge clk);
      chk("cnt_pre_clr", 32'(mis_cnt), 3);
      @(posedge clk); #1 cnt_clr = 1'b1; rsp_ready = 1'b1; req_valid = '0;
      @(posedge clk); #1 cnt_clr = 1'b0;
      @(negedge clk);
      chk("cnt_clr_wins", 32'(mis_cnt), 0);
      step(4);
    end
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
